// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Frame geometry, CRC-4 polynomial, receiver state encoding and a
//            single-bit CRC step helper shared by bus transmitter and receiver.
// Revision : 1.0  initial release
// ============================================================================
package bus_pkg;

  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 64;
  localparam int CRC_W      = 4;
  localparam int FRAME_BITS = 1 + ADDR_W + DATA_W + CRC_W + 1;  // 74
  localparam int SHIFT_W    = ADDR_W + DATA_W + CRC_W;          // 72
  localparam int CNT_W      = 7;

  localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;              // x^4+x+1

  // Bit-counter values of the last bit of each field (counter starts at 0
  // on the first address bit and runs across the whole body).
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(ADDR_W + DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(SHIFT_W - 1);

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0,
    RX_ADDR = 3'd1,
    RX_DATA = 3'd2,
    RX_CRC  = 3'd3,
    RX_STOP = 3'd4
  } rx_state_e;

  function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] crc,
                                                 input logic             b);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc4_serial.sv
`default_nettype none
// ============================================================================
// Module   : crc4_serial
// Purpose  : Bit-serial CRC-4 accumulator (x^4+x+1, init 0), MSB first.
//            Clear has priority over enable.
// Revision : 1.0  initial release
// ============================================================================
module crc4_serial
  import bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q, crc_d;

  // Next CRC: clear restarts from zero, enable folds in one bus bit
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = crc4_step(crc_q, bit_i);
    end
  end

  // CRC register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/bus_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : bus_frame_receiver
// Purpose  : Deserializes 74-bit bus frames (start, addr, data, crc, stop),
//            filters on MY_ADDR and hands good payloads to a one-entry
//            valid/ready buffer. Error/overrun flags are one-cycle pulses.
// Config   : RX_CRC_CHECK_EN - when defined the CRC field is checked and
//            crc_err is live; otherwise the CRC field is consumed and ignored.
// Revision : 1.0  initial release
// ============================================================================
module bus_frame_receiver
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MY_ADDR = 4'd1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bus_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              crc_err,
  output logic              frame_err,
  output logic              overrun
);

  rx_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;

  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                crc_err_q, crc_err_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic                w_addr_ok;
  logic                w_crc_ok;

  // Frame sequencing: counter runs across addr/data/crc, shift captures them
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    unique case (state_q)
      RX_IDLE: begin
        if (bus_in) begin
          state_d = RX_ADDR;
          cnt_d   = '0;
        end
      end
      RX_ADDR, RX_DATA, RX_CRC: begin
        shift_d = {shift_q[SHIFT_W-2:0], bus_in};
        cnt_d   = cnt_q + 1'b1;
        if (state_q == RX_ADDR && cnt_q == ADDR_LAST) state_d = RX_DATA;
        if (state_q == RX_DATA && cnt_q == DATA_LAST) state_d = RX_CRC;
        if (state_q == RX_CRC  && cnt_q == CRC_LAST)  state_d = RX_STOP;
      end
      RX_STOP: begin
        // The stop bit is always consumed here, never reused as a start bit
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // FSM, counter and shift register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign w_addr_ok = (shift_q[SHIFT_W-1 -: ADDR_W] == MY_ADDR);

`ifdef RX_CRC_CHECK_EN
  logic [CRC_W-1:0] w_crc_calc;

  crc4_serial u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_i ((state_q == RX_IDLE) && bus_in),
    .en_i    ((state_q == RX_ADDR) || (state_q == RX_DATA)),
    .bit_i   (bus_in),
    .crc_o   (w_crc_calc)
  );

  assign w_crc_ok = (shift_q[CRC_W-1:0] == w_crc_calc);
`else
  logic w_crc_field_unused;
  assign w_crc_field_unused = ^shift_q[CRC_W-1:0];
  assign w_crc_ok           = 1'b1;
`endif

  // End-of-frame decision and output buffer handshake
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_ready;
    crc_err_d   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    if (state_q == RX_STOP && w_addr_ok) begin
      if (bus_in) begin
        frame_err_d = 1'b1;
      end else if (!w_crc_ok) begin
        crc_err_d = 1'b1;
      end else if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q[SHIFT_W-1-ADDR_W -: DATA_W];
        rx_valid_d = 1'b1;
      end
    end
  end

  // Output buffer and flag registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign crc_err   = crc_err_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_frame_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bus_frame_receiver
// Purpose  : Directed self-checking bench for bus_frame_receiver (MY_ADDR=1).
//            Expectations follow RX_CRC_CHECK_EN when it is defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_bus_frame_receiver;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        bus_in   = 1'b0;
  logic        rx_ready = 1'b0;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        crc_err;
  logic        frame_err;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] DB = 64'hDEAD_BEEF_1234_5678;

  always #5 clock = ~clock;

  bus_frame_receiver #(.MY_ADDR(4'd1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus_in    (bus_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .crc_err   (crc_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic ce, input logic fe, input logic ov);
    chk({tag, ".crc_err"},   64'(crc_err),   64'(ce));
    chk({tag, ".frame_err"}, 64'(frame_err), 64'(fe));
    chk({tag, ".overrun"},   64'(overrun),   64'(ov));
  endtask

  // Reference CRC-4 over {addr, data}, MSB first
  function automatic logic [3:0] ref_crc(input logic [3:0] a, input logic [63:0] d);
    logic [67:0] m;
    logic [3:0]  c;
    logic        fb;
    m = {a, d};
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ m[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  // Drive one bit; it is sampled by the posedge inside the wait
  task automatic tick(input logic b);
    bus_in = b;
    @(negedge clock);
  endtask

  // Send the first nbits of a frame, MSB (start bit) first
  task automatic send(input logic [3:0] a, input logic [63:0] d, input logic [3:0] c,
                      input logic stop, input int nbits);
    logic [73:0] f;
    f = {1'b1, a, d, c, stop};
    for (int i = 73; i > 73 - nbits; i--) tick(f[i]);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    tick(1'b0);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    chk("reset.rx_valid", 64'(rx_valid), 64'd0);
    chk("reset.rx_data",  rx_data,       64'd0);
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick(1'b0);

    // Good frame addr=1 data=1 crc=6: nothing before the stop edge, then valid
    send(4'd1, 64'h1, 4'h6, 1'b0, 73);
    chk("t1.pre_valid", 64'(rx_valid), 64'd0);
    tick(1'b0);
    chk("t1.valid", 64'(rx_valid), 64'd1);
    chk("t1.data",  rx_data,       64'h1);
    chk_flags("t1", 1'b0, 1'b0, 1'b0);
    drain();
    chk("t1.drained", 64'(rx_valid), 64'd0);

    // data=0 with crc=6 (correct would be 5)
    send(4'd1, 64'h0, 4'h6, 1'b0, 74);
`ifdef RX_CRC_CHECK_EN
    chk("t2.crc_err", 64'(crc_err),  64'd1);
    chk("t2.valid",   64'(rx_valid), 64'd0);
    tick(1'b0);
    chk("t2.crc_err_pulse", 64'(crc_err), 64'd0);
`else
    chk("t2.valid", 64'(rx_valid), 64'd1);
    chk("t2.data",  rx_data,       64'h0);
    chk_flags("t2", 1'b0, 1'b0, 1'b0);
    drain();
`endif

    // Foreign address, then a good frame back-to-back
    send(4'd2, 64'h1, 4'h6, 1'b0, 74);
    chk("t3.foreign_valid", 64'(rx_valid), 64'd0);
    chk_flags("t3.foreign", 1'b0, 1'b0, 1'b0);
    send(4'd1, 64'h1, 4'h6, 1'b0, 74);
    chk("t3.valid", 64'(rx_valid), 64'd1);
    chk("t3.data",  rx_data,       64'h1);
    drain();

    // Two good frames back-to-back, consumer stalled -> overrun, old payload kept
    send(4'd1, 64'h1, 4'h6, 1'b0, 74);
    chk("t4.first_valid", 64'(rx_valid), 64'd1);
    chk("t4.first_data",  rx_data,       64'h1);
    send(4'd1, DB, ref_crc(4'd1, DB), 1'b0, 74);
    chk_flags("t4.second", 1'b0, 1'b0, 1'b1);
    chk("t4.held_valid", 64'(rx_valid), 64'd1);
    chk("t4.held_data",  rx_data,       64'h1);
    tick(1'b0);
    chk("t4.overrun_pulse", 64'(overrun), 64'd0);
    drain();

    // Same pair with consumer always ready -> both delivered
    rx_ready = 1'b1;
    send(4'd1, 64'h1, 4'h6, 1'b0, 74);
    chk("t5.first_valid", 64'(rx_valid), 64'd1);
    chk("t5.first_data",  rx_data,       64'h1);
    send(4'd1, DB, ref_crc(4'd1, DB), 1'b0, 74);
    chk("t5.second_valid", 64'(rx_valid), 64'd1);
    chk("t5.second_data",  rx_data,       DB);
    chk_flags("t5.second", 1'b0, 1'b0, 1'b0);
    tick(1'b0);
    chk("t5.drained", 64'(rx_valid), 64'd0);
    rx_ready = 1'b0;

    // Stop bit 1 -> frame_err; a frame right behind it must still align
    send(4'd1, 64'h1, 4'h6, 1'b1, 74);
    chk_flags("t6.bad_stop", 1'b0, 1'b1, 1'b0);
    chk("t6.bad_stop_valid", 64'(rx_valid), 64'd0);
    send(4'd1, 64'h2, ref_crc(4'd1, 64'h2), 1'b0, 74);
    chk("t6.next_valid", 64'(rx_valid), 64'd1);
    chk("t6.next_data",  rx_data,       64'h2);
    chk_flags("t6.next", 1'b0, 1'b0, 1'b0);

    // Reset mid-frame with a payload pending, then one full good frame
    send(4'd1, 64'h5, ref_crc(4'd1, 64'h5), 1'b0, 31);
    reset_n = 1'b0;
    tick(1'b0);
    chk("t7.rst_valid", 64'(rx_valid), 64'd0);
    chk("t7.rst_data",  rx_data,       64'd0);
    chk_flags("t7.rst", 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    tick(1'b0);
    chk("t7.aborted_valid", 64'(rx_valid), 64'd0);
    send(4'd1, 64'hA5, ref_crc(4'd1, 64'hA5), 1'b0, 74);
    chk("t7.valid", 64'(rx_valid), 64'd1);
    chk("t7.data",  rx_data,       64'hA5);
    chk_flags("t7", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
